// File: rtl/pipe_stall_if.sv
// Stall/flush handshake between the pipeline request sources and the stall controller.
interface pipe_stall_if #(
  parameter int CNT_W = 16
);
  logic             hazard_i;
  logic             dmem_req_i;
  logic             dmem_ack_i;
  logic             branch_taken_i;
  logic             PCWrite_o;
  logic             IFIDWrite_o;
  logic             IFIDFlush_o;
  logic             IDEXBubble_o;
  logic             PipeFreeze_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic             timeout_o;

  // Request side: hazard detector, MEM responder, ID branch unit
  modport master (
    output hazard_i, dmem_req_i, dmem_ack_i, branch_taken_i,
    input  PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXBubble_o, PipeFreeze_o,
    input  state_o, stall_cnt_o, timeout_o
  );

  // Controller side
  modport slave (
    input  hazard_i, dmem_req_i, dmem_ack_i, branch_taken_i,
    output PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXBubble_o, PipeFreeze_o,
    output state_o, stall_cnt_o, timeout_o
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: arbitrates memory wait, load-use stall and
// branch flush; Mealy outputs, registered state, stall counter and timeout flag.
module pipe_stall_ctrl #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  pipe_stall_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    MEM_WAIT   = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             timeout_q, timeout_d;

  logic pc_wr, ifid_wr, ifid_fl, idex_bub, freeze;
  logic mem_wait;

  assign mem_wait = bus.dmem_req_i & ~bus.dmem_ack_i;

  // Next-state and Mealy output decode
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pc_wr      = 1'b1;
    ifid_wr    = 1'b1;
    ifid_fl    = 1'b0;
    idex_bub   = 1'b0;
    freeze     = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_wait) begin
          pc_wr      = 1'b0;
          ifid_wr    = 1'b0;
          freeze     = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = CNT_W'(1);
        end else if (bus.hazard_i) begin
          pc_wr    = 1'b0;
          ifid_wr  = 1'b0;
          idex_bub = 1'b1;
          state_d  = LOAD_STALL;
        end else if (bus.branch_taken_i) begin
          ifid_fl = 1'b1;
        end
      end
      LOAD_STALL: begin
        // hazard_i is deliberately not looked at here: one bubble per load-use
        if (mem_wait) begin
          pc_wr      = 1'b0;
          ifid_wr    = 1'b0;
          freeze     = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = CNT_W'(1);
        end else begin
          ifid_fl = bus.branch_taken_i;
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (!bus.dmem_ack_i) begin
          pc_wr   = 1'b0;
          ifid_wr = 1'b0;
          freeze  = 1'b1;
          if (wait_cnt_q != MAX_WAIT_C) wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end else begin
          ifid_fl    = bus.branch_taken_i;
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Stall counter and sticky timeout next values
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_wr && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    timeout_d = timeout_q | (wait_cnt_d == MAX_WAIT_C);
  end

  // State, counter and flag registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // Every output is forced low while reset is held
  always_comb begin
    bus.PCWrite_o    = pc_wr & ~rst_i;
    bus.IFIDWrite_o  = ifid_wr & ~rst_i;
    bus.IFIDFlush_o  = ifid_fl & ~rst_i;
    bus.IDEXBubble_o = idex_bub & ~rst_i;
    bus.PipeFreeze_o = freeze & ~rst_i;
    bus.state_o      = rst_i ? 2'b00 : state_q;
    bus.stall_cnt_o  = rst_i ? '0 : stall_cnt_q;
    bus.timeout_o    = timeout_q & ~rst_i;
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed plan steps then random cycles
// against a rule-level reference model.
module tb_pipe_stall_ctrl;
  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  pipe_stall_if #(.CNT_W(CNT_W)) bus ();

  pipe_stall_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  int compared = 0;
  int mismatched = 0;

  // Reference model: waiting / just-bubbled flags and plain integer counters
  bit m_waiting = 0;
  bit m_bubbled = 0;
  int m_waited  = 0;
  int m_stalls  = 0;
  bit m_timeout = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, check outputs mid-cycle, advance model at edge
  task automatic cyc(input bit r, input bit h, input bit req, input bit ack, input bit br);
    bit e_pc, e_w, e_f, e_b, e_z, wait_now;
    int e_st;
    rst_i = r;
    bus.hazard_i = h;
    bus.dmem_req_i = req;
    bus.dmem_ack_i = ack;
    bus.branch_taken_i = br;
    #3;
    wait_now = m_waiting ? !ack : (req && !ack);
    e_st = m_waiting ? 2 : (m_bubbled ? 1 : 0);
    e_pc = 1; e_w = 1; e_f = 0; e_b = 0; e_z = 0;
    if (wait_now) begin
      e_pc = 0; e_w = 0; e_z = 1;
    end else if (!m_waiting && !m_bubbled && h) begin
      e_pc = 0; e_w = 0; e_b = 1;
    end else if (br) begin
      e_f = 1;
    end
    if (r) begin
      chk("rst_pc",    32'(bus.PCWrite_o),    0);
      chk("rst_ifidw", 32'(bus.IFIDWrite_o),  0);
      chk("rst_flush", 32'(bus.IFIDFlush_o),  0);
      chk("rst_bub",   32'(bus.IDEXBubble_o), 0);
      chk("rst_frz",   32'(bus.PipeFreeze_o), 0);
      chk("rst_state", 32'(bus.state_o),      0);
      chk("rst_cnt",   32'(bus.stall_cnt_o),  0);
      chk("rst_to",    32'(bus.timeout_o),    0);
    end else begin
      chk("pc",    32'(bus.PCWrite_o),    32'(e_pc));
      chk("ifidw", 32'(bus.IFIDWrite_o),  32'(e_w));
      chk("flush", 32'(bus.IFIDFlush_o),  32'(e_f));
      chk("bub",   32'(bus.IDEXBubble_o), 32'(e_b));
      chk("frz",   32'(bus.PipeFreeze_o), 32'(e_z));
      chk("state", 32'(bus.state_o),      32'(e_st));
      chk("cnt",   32'(bus.stall_cnt_o),  32'(m_stalls));
      chk("to",    32'(bus.timeout_o),    32'(m_timeout));
    end
    @(posedge clk_i);
    if (r) begin
      m_waiting = 0; m_bubbled = 0; m_waited = 0; m_stalls = 0; m_timeout = 0;
    end else begin
      if (!e_pc && m_stalls < CNT_MAX) m_stalls++;
      if (wait_now) begin
        m_waited = m_waiting ? ((m_waited < MAX_WAIT) ? m_waited + 1 : MAX_WAIT) : 1;
        if (m_waited == MAX_WAIT) m_timeout = 1;
        m_waiting = 1;
        m_bubbled = 0;
      end else begin
        m_waiting = 0;
        m_waited  = 0;
        m_bubbled = e_b;
      end
    end
    #2;
  endtask

  initial begin
    rst_i = 1'b1;
    bus.hazard_i = 0; bus.dmem_req_i = 0; bus.dmem_ack_i = 0; bus.branch_taken_i = 0;
    @(posedge clk_i);
    #2;

    // 1. reset then idle
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 0, 0);

    // 2. load-use stall, hazard held three cycles
    repeat (3) cyc(0, 1, 0, 0, 0);
    chk("t2_cnt", 32'(bus.stall_cnt_o), 2);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // 3. memory wait with timeout, then ack
    repeat (6) cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0);
    chk("t3_to",  32'(bus.timeout_o), 1);
    chk("t3_cnt", 32'(bus.stall_cnt_o), 8);
    cyc(0, 0, 0, 0, 0);

    // 4. simultaneous requests; memory wins, hazard re-evaluated after ack
    cyc(0, 1, 1, 0, 1);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // 5. branch flush in RUN
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);

    // 6. reset in MEM_WAIT with timeout set
    repeat (5) cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Random traffic, including counter saturation and occasional reset
    for (int i = 0; i < 400; i++) begin
      bit r, h, rq, ak, br;
      r  = ($urandom_range(39) == 0);
      h  = ($urandom_range(2) == 0);
      rq = ($urandom_range(1) == 0);
      ak = m_waiting ? ($urandom_range(3) == 0) : ($urandom_range(1) == 0);
      br = ($urandom_range(3) == 0);
      cyc(r, h, rq, ak, br);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
